// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared definitions for the fully-connected layer sequencer: state encodings,
// default layer sizes shared with the address generator and ALU, and a width helper.
package neuron_layer_sequencer_pkg;

  localparam int DEF_N_INPUTS  = 4;
  localparam int DEF_N_NEURONS = 3;
  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_IDX_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_BIAS  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } seq_state_e;

  // Bits needed to hold max_val (at least one).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_seq_counter.sv
// Up-counter with exact terminal-count compare; on enable at the terminal value it
// returns to zero, so the count never exceeds TC.
module seq_counter #(
  parameter int W  = 8,
  parameter int TC = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(TC));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Control sequencer for one fully-connected layer: clears, reads, drains and writes
// back each neuron in turn. Define SEQ_BIAS_EN to add a one-cycle BIAS state per neuron.
//
// state | meaning
// IDLE  | waiting for start (blocked while hold)
// CLR   | clear address generator and accumulator for this neuron
// READ  | one AG_read per input, in_idx 0..N_INPUTS-1
// DRAIN | wait RD_LAT cycles for the last product (skipped when RD_LAT==0)
// BIAS  | bias read, accumulated immediately (SEQ_BIAS_EN only)
// WRITE | write neuron result at neuron_idx
// DONE  | one-cycle done pulse, then back to IDLE
module neuron_layer_sequencer
  import neuron_layer_sequencer_pkg::*;
#(
  parameter int N_INPUTS  = DEF_N_INPUTS,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             AG_rst,
  output logic             AG_read,
  output logic [IDX_W-1:0] in_idx,
  output logic             ALU_rst,
  output logic             mac_en,
  output logic             bias_rd,
  output logic             wr_en,
  output logic [IDX_W-1:0] neuron_idx,
  output logic [IDX_W-1:0] wr_addr
);

  localparam int DR_TC = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam int DR_W  = cnt_width(DR_TC);

  seq_state_e state, state_nxt;

  logic            in_clr, in_en, in_last;
  logic            dr_clr, dr_en, dr_last;
  logic            nr_clr, nr_en, nr_last;
  logic [DR_W-1:0] dr_count;
  logic            mac_dly;
  seq_state_e      after_read;

  seq_counter #(.W(IDX_W), .TC(N_INPUTS - 1)) u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (in_clr),
    .en    (in_en),
    .count (in_idx),
    .last  (in_last)
  );

  seq_counter #(.W(DR_W), .TC(DR_TC)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (dr_clr),
    .en    (dr_en),
    .count (dr_count),
    .last  (dr_last)
  );

  seq_counter #(.W(IDX_W), .TC(N_NEURONS - 1)) u_neuron_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (nr_clr),
    .en    (nr_en),
    .count (neuron_idx),
    .last  (nr_last)
  );

  assign wr_addr = neuron_idx;
  assign busy    = (state != ST_IDLE);

`ifdef SEQ_BIAS_EN
  assign after_read = ST_BIAS;
`else
  assign after_read = ST_WRITE;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every strobe and counter step is qualified by !hold so a stalled action repeats on release.
  always_comb begin
    state_nxt = state;
    AG_rst    = 1'b0;
    ALU_rst   = 1'b0;
    AG_read   = 1'b0;
    bias_rd   = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    in_clr    = 1'b0;
    in_en     = 1'b0;
    dr_clr    = 1'b0;
    dr_en     = 1'b0;
    nr_clr    = 1'b0;
    nr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !hold) begin
          state_nxt = ST_CLR;
          nr_clr    = 1'b1;
        end
      end
      ST_CLR: begin
        AG_rst  = !hold;
        ALU_rst = !hold;
        if (!hold) begin
          in_clr    = 1'b1;
          dr_clr    = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        AG_read = !hold;
        if (!hold) begin
          in_en = 1'b1;
          if (in_last) begin
            state_nxt = (RD_LAT > 0) ? ST_DRAIN : after_read;
          end
        end
      end
      ST_DRAIN: begin
        if (!hold) begin
          dr_en = 1'b1;
          if (dr_last) state_nxt = after_read;
        end
      end
`ifdef SEQ_BIAS_EN
      ST_BIAS: begin
        bias_rd = !hold;
        if (!hold) state_nxt = ST_WRITE;
      end
`endif
      ST_WRITE: begin
        wr_en = !hold;
        if (!hold) begin
          if (nr_last) begin
            state_nxt = ST_DONE;
          end else begin
            nr_en     = 1'b1;
            state_nxt = ST_CLR;
          end
        end
      end
      ST_DONE: begin
        done = !hold;
        if (!hold) begin
          nr_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read-to-accumulate delay line; it keeps shifting through hold and sees the gated AG_read.
  generate
    if (RD_LAT == 0) begin : g_no_dly
      assign mac_dly = AG_read;
    end else begin : g_dly
      logic [RD_LAT-1:0] pipe;
      always_ff @(posedge clk) begin
        if (!reset) begin
          pipe <= '0;
        end else begin
          pipe[0] <= AG_read;
          for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mac_dly = pipe[RD_LAT-1];
    end
  endgenerate

  // The bias term needs no memory latency compensation: it accumulates in its own cycle.
  assign mac_en = mac_dly | bias_rd;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Scoreboard bench for neuron_layer_sequencer at default sizes plus a minimal 1x1, RD_LAT=0 instance.
module tb_neuron_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int RL = 2;
  localparam int IW = 8;
`ifdef SEQ_BIAS_EN
  localparam int BI = 1;
`else
  localparam int BI = 0;
`endif
  localparam int PER = 2 + NI + RL + BI;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic busy, done, ag_rst, ag_read, alu_rst, mac_en, bias_rd, wr_en;
  logic [IW-1:0] in_idx, neuron_idx, wr_addr;

  logic s_start = 1'b0;
  logic s_hold = 1'b0;
  logic s_busy, s_done, s_ag_rst, s_ag_read, s_alu_rst, s_mac_en, s_bias_rd, s_wr_en;
  logic [IW-1:0] s_in_idx, s_neuron_idx, s_wr_addr;

  logic [31:0] outs, s_outs;
  assign outs   = {busy, done, ag_rst, ag_read, alu_rst, mac_en, bias_rd, wr_en,
                   in_idx, neuron_idx, wr_addr};
  assign s_outs = {s_busy, s_done, s_ag_rst, s_ag_read, s_alu_rst, s_mac_en, s_bias_rd, s_wr_en,
                   s_in_idx, s_neuron_idx, s_wr_addr};

  neuron_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .RD_LAT(RL), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .busy(busy), .done(done),
    .AG_rst(ag_rst), .AG_read(ag_read), .in_idx(in_idx), .ALU_rst(alu_rst), .mac_en(mac_en),
    .bias_rd(bias_rd), .wr_en(wr_en), .neuron_idx(neuron_idx), .wr_addr(wr_addr)
  );

  neuron_layer_sequencer #(.N_INPUTS(1), .N_NEURONS(1), .RD_LAT(0), .IDX_W(IW)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .hold(s_hold), .busy(s_busy), .done(s_done),
    .AG_rst(s_ag_rst), .AG_read(s_ag_read), .in_idx(s_in_idx), .ALU_rst(s_alu_rst),
    .mac_en(s_mac_en), .bias_rd(s_bias_rd), .wr_en(s_wr_en), .neuron_idx(s_neuron_idx),
    .wr_addr(s_wr_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int addr;
    int cyc;
  } wr_exp_t;

  wr_exp_t wr_q[$];
  int      done_q[$];
  int      mac_q[$];
  int      ag_cnt = 0;
  int      mac_cnt = 0;
  bit      mon_en = 1'b0;

  // Output monitor for the default-size instance.
  always @(negedge clk) begin : monitor
    wr_exp_t w;
    int      e;
    if (mon_en && reset) begin
      if (ag_read) begin
        ag_cnt++;
        mac_q.push_back(cyc + RL);
      end
      if (bias_rd) begin
        mac_q.push_back(cyc);
        if (wr_q.size() == 0) check("bias_unexpected", 1, 0);
        else check("bias_addr", neuron_idx, wr_q[0].addr);
      end
      if (mac_q.size() > 0 && mac_q[0] < cyc) begin
        e = mac_q.pop_front();
        check("mac_missing", cyc, e);
      end
      if (mac_en) begin
        mac_cnt++;
        if (mac_q.size() == 0) check("mac_stray", 1, 0);
        else begin
          e = mac_q.pop_front();
          check("mac_cycle", cyc, e);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", wr_addr, w.addr);
          check("wr_neuron_idx", neuron_idx, w.addr);
          check("wr_cycle", cyc, w.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = done_q.pop_front();
          check("done_cycle", cyc, e);
          check("ag_read_count", ag_cnt, NN * NI);
          check("mac_en_count", mac_cnt, NN * (NI + BI));
        end
      end
    end
  end

  task automatic push_pass(input int a, input int hold_len);
    for (int k = 0; k < NN; k++) wr_q.push_back('{k, a - 1 + (k + 1) * PER + hold_len});
    done_q.push_back(a + NN * PER + hold_len);
    ag_cnt  = 0;
    mac_cnt = 0;
  endtask

  task automatic launch(input int hold_len, input bit keep, output int a);
    a     = cyc + 1;
    start = 1'b1;
    push_pass(a, hold_len);
    @(posedge clk); #1;
    if (!keep) start = 1'b0;
    check("busy_after_start", busy, 1);
    check("clr_strobes", {ag_rst, alu_rst}, 2'b11);
    check("clr_in_idx", in_idx, 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int a, a2, sa, wr_c, bias_c, done_c, mac_first, s_mac_cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", outs, 0);
    check("s_rst_outs", s_outs, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Plain pass, with a start pulse while busy that must be ignored
    launch(0, 1'b0, a);
    wait_until(a + 9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    check("idle_after_done", busy, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("no_restart", busy, 0);

    // Hold for 3 cycles at in_idx=2 of neuron 0
    launch(3, 1'b0, a);
    wait_until(a + 3);
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("hold_in_idx", in_idx, 2);
      check("hold_ag_read", ag_read, 0);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    @(negedge clk);
    check("resume_in_idx", in_idx, 2);
    check("resume_ag_read", ag_read, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("resume_next_idx", in_idx, 3);
    @(posedge clk); #1;
    wait_done(100);

    // Reset mid-READ of neuron 1
    launch(0, 1'b0, a);
    wait_until(a + PER + 2);
    check("pre_rst_neuron", neuron_idx, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    wr_q.delete();
    done_q.delete();
    mac_q.delete();
    @(negedge clk);
    check("midrst_outs", outs, 0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check("midrst_mac", mac_en, 0);
    end
    launch(0, 1'b0, a);
    check("replay_neuron", neuron_idx, 0);
    wait_done(100);

    // Start held high through a full pass
    launch(0, 1'b1, a);
    wait_done(100);
    check("held_idle_gap", busy, 0);
    a2 = cyc + 1;
    push_pass(a2, 0);
    @(posedge clk); #1;
    check("held_restart", busy, 1);
    check("held_restart_clr", ag_rst, 1);
    wait_until(a2 + 5);
    start = 1'b0;
    wait_done(100);
    check("queues_empty", wr_q.size() + done_q.size(), 0);

    // Minimal layer: 1 input, 1 neuron, no read latency
    sa        = cyc + 1;
    s_start   = 1'b1;
    wr_c      = -1;
    bias_c    = -1;
    done_c    = -1;
    mac_first = -1;
    s_mac_cnt = 0;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (s_wr_en && wr_c < 0) wr_c = cyc;
      if (s_bias_rd && bias_c < 0) bias_c = cyc;
      if (s_done && done_c < 0) done_c = cyc;
      if (s_mac_en) begin
        s_mac_cnt++;
        if (mac_first < 0) mac_first = cyc;
      end
      @(posedge clk); #1;
    end
    check("s_done_latency", done_c - (sa - 1), 4 + BI);
    check("s_wr_cycle", wr_c, sa + 2 + BI);
    check("s_bias_cycle", bias_c, (BI == 1) ? wr_c - 1 : -1);
    check("s_mac_first", mac_first, sa + 1);
    check("s_mac_count", s_mac_cnt, 1 + BI);
    check("s_idle_end", s_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
